// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler that shares one I2C DAC write engine among NUM_CH channels,
// with per-channel last-write-wins mailboxes, retry on failed writes and optional refresh.

module dac_ch_mailbox #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [DW-1:0] req_value,
    input  logic          clr,
    input  logic          refresh_load,
    input  logic          commit,
    input  logic [DW-1:0] commit_value,
    output logic [DW-1:0] shadow,
    output logic          pending,
    output logic [DW-1:0] committed
);
    // A user strobe beats both the scheduler clear and a refresh reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else if (req_valid) begin
            shadow  <= req_value;
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end else if (refresh_load && !pending) begin
            shadow  <= committed;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         committed <= '0;
        else if (commit) committed <= commit_value;
    end
endmodule

module dac_update_scheduler #(
    parameter int NUM_CH         = 2,
    parameter int CH_W           = 1,
    parameter int DW             = 12,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*DW-1:0] req_value,
    input  logic                 refresh_en,
    input  logic                 err_clr,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [CH_W-1:0]      wr_ch,
    output logic [DW-1:0]        wr_value,
    input  logic                 wr_done,
    input  logic                 wr_err,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH*DW-1:0] committed_value,
    output logic                 busy,
    output logic                 err_sticky,
    output logic [CH_W-1:0]      err_ch
);
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int RC  = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES : 1;
    localparam int RW  = $clog2(RC) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                    state, state_n;
    logic [CH_W-1:0]           sel, sel_n, rr, rr_n, pick;
    logic [DW-1:0]             snap, snap_n;
    logic [RTW-1:0]            retry, retry_n;
    logic [TW-1:0]             timer, timer_n;
    logic [RW-1:0]             rcnt;
    logic                      found, err_set, refresh_wrap;
    logic [NUM_CH-1:0]         clr_vec, commit_vec;
    logic [NUM_CH-1:0][DW-1:0] shadow, committed;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            dac_ch_mailbox #(.DW(DW)) u_mbox (
                .clk          (clk),
                .rst          (rst),
                .req_valid    (req_valid[gi]),
                .req_value    (req_value[gi*DW +: DW]),
                .clr          (clr_vec[gi]),
                .refresh_load (refresh_wrap),
                .commit       (commit_vec[gi]),
                .commit_value (snap),
                .shadow       (shadow[gi]),
                .pending      (pending[gi]),
                .committed    (committed[gi])
            );
        end
    endgenerate

    assign committed_value = committed;
    assign busy            = (state != IDLE) || (|pending);

    // Scan starts one past the last served channel, so ch rr is considered last.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found && pending[(int'(rr) + k) % NUM_CH]) begin
                found = 1'b1;
                pick  = CH_W'((int'(rr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        rr_n       = rr;
        snap_n     = snap;
        retry_n    = retry;
        timer_n    = timer;
        clr_vec    = '0;
        commit_vec = '0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n         = pick;
                    rr_n          = pick;
                    snap_n        = shadow[pick];
                    retry_n       = '0;
                    clr_vec[pick] = 1'b1;
                    state_n       = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    timer_n = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                timer_n = timer + 1'b1;
                if (wr_done && !wr_err) begin
                    commit_vec[sel] = 1'b1;
                    state_n         = IDLE;
                end else if ((wr_done && wr_err) || (timer == TW'(TIMEOUT_CYCLES - 1))) begin
                    if (retry < RTW'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = ISSUE;
                    end else begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr       <= CH_W'(NUM_CH - 1);
            snap     <= '0;
            retry    <= '0;
            timer    <= '0;
            wr_valid <= 1'b0;
            wr_ch    <= '0;
            wr_value <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            rr       <= rr_n;
            snap     <= snap_n;
            retry    <= retry_n;
            timer    <= timer_n;
            wr_valid <= (state_n == ISSUE);
            wr_ch    <= sel_n;
            wr_value <= snap_n;
        end
    end

    // A new abandon in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_ch     <= '0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
            err_ch     <= sel;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    assign refresh_wrap = (REFRESH_CYCLES > 0) && refresh_en && (rcnt == RW'(RC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   rcnt <= '0;
        else if (!refresh_en || REFRESH_CYCLES == 0) rcnt <= '0;
        else if (refresh_wrap)                     rcnt <= '0;
        else                                       rcnt <= rcnt + 1'b1;
    end
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler: single write, coalescing, round-robin,
// retry, timeout abandon, refresh and mid-transaction reset.

module tb_dac_update_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [23:0] req_value;
    logic        refresh_en, err_clr;
    logic        wr_valid, wr_ready;
    logic [0:0]  wr_ch;
    logic [11:0] wr_value;
    logic        wr_done, wr_err;
    logic [1:0]  pending;
    logic [23:0] committed_value;
    logic        busy, err_sticky;
    logic [0:0]  err_ch;

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int n, hs0;

    always #5 clk = ~clk;

    dac_update_scheduler #(
        .NUM_CH(2), .CH_W(1), .DW(12), .MAX_RETRY(2),
        .TIMEOUT_CYCLES(16), .REFRESH_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
        .refresh_en(refresh_en), .err_clr(err_clr), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_value(wr_value), .wr_done(wr_done),
        .wr_err(wr_err), .pending(pending), .committed_value(committed_value),
        .busy(busy), .err_sticky(err_sticky), .err_ch(err_ch)
    );

    always @(posedge clk) if (!rst && wr_valid && wr_ready) hs <= hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] m, input logic [11:0] v0, input logic [11:0] v1);
        req_valid = m;
        req_value = {v1, v0};
        tick();
        req_valid = '0;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (!wr_valid && cnt < budget) begin
            tick();
            cnt++;
        end
        if (!wr_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input string tag, input logic [0:0] ch, input logic [11:0] v);
        int c;
        wait_valid(250, c);
        chk({tag, "_ch"}, 32'(wr_ch), 32'(ch));
        chk({tag, "_val"}, 32'(wr_value), 32'(v));
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk({tag, "_drop"}, 32'(wr_valid), 32'd0);
    endtask

    task automatic done(input logic e);
        wr_done = 1'b1;
        wr_err  = e;
        tick();
        wr_done = 1'b0;
        wr_err  = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [0:0] ch, input logic [11:0] v, input logic e);
        accept(tag, ch, v);
        done(e);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_value = '0; refresh_en = 1'b0; err_clr = 1'b0;
        wr_ready = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_committed", 32'(committed_value), 32'd0);

        // 1: single write with latency check
        req_valid = 2'b01; req_value = {12'h000, 12'h5A3};
        tick();
        req_valid = '0;
        chk("t1_pend", 32'(pending), 32'd1);
        chk("t1_lat_early", 32'(wr_valid), 32'd0);
        tick();
        chk("t1_lat_valid", 32'(wr_valid), 32'd1);
        chk("t1_ch", 32'(wr_ch), 32'd0);
        chk("t1_val", 32'(wr_value), 32'h5A3);
        chk("t1_pend_clr", 32'(pending), 32'd0);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("t1_drop", 32'(wr_valid), 32'd0);
        done(1'b0);
        chk("t1_commit", 32'(committed_value[11:0]), 32'h5A3);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: coalescing while the writer stalls on ch0
        strobe(2'b01, 12'h111, 12'h000);
        wait_valid(10, n);
        strobe(2'b10, 12'h000, 12'h100);
        strobe(2'b10, 12'h000, 12'h200);
        strobe(2'b10, 12'h000, 12'h300);
        chk("t2_hold_valid", 32'(wr_valid), 32'd1);
        chk("t2_hold_ch", 32'(wr_ch), 32'd0);
        chk("t2_hold_val", 32'(wr_value), 32'h111);
        serve("t2_w0", 1'b0, 12'h111, 1'b0);
        hs0 = hs;
        serve("t2_w1", 1'b1, 12'h300, 1'b0);
        repeat (8) tick();
        chk("t2_once", 32'(hs - hs0), 32'd1);
        chk("t2_idle", 32'(wr_valid), 32'd0);
        chk("t2_commit1", 32'(committed_value[23:12]), 32'h300);

        // 3: round-robin with both channels kept pending
        strobe(2'b11, 12'hA00, 12'hB00);
        serve("t3_a", 1'b0, 12'hA00, 1'b0);
        strobe(2'b01, 12'hA01, 12'h000);
        serve("t3_b", 1'b1, 12'hB00, 1'b0);
        strobe(2'b10, 12'h000, 12'hB01);
        serve("t3_c", 1'b0, 12'hA01, 1'b0);
        serve("t3_d", 1'b1, 12'hB01, 1'b0);
        chk("t3_commit", 32'(committed_value), 32'hB01A01);

        // 4: two NACKs then success
        strobe(2'b10, 12'h000, 12'h7E5);
        serve("t4_try0", 1'b1, 12'h7E5, 1'b1);
        serve("t4_try1", 1'b1, 12'h7E5, 1'b1);
        serve("t4_try2", 1'b1, 12'h7E5, 1'b0);
        chk("t4_commit", 32'(committed_value[23:12]), 32'h7E5);
        chk("t4_err", 32'(err_sticky), 32'd0);

        // 5: timeout on every attempt, err_clr held through the final one
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        chk("t5_stray_done", 32'(busy), 32'd0);
        strobe(2'b01, 12'h333, 12'h000);
        accept("t5_try0", 1'b0, 12'h333);
        wait_valid(60, n);
        chk("t5_timeout_cycles", 32'(n), 32'd16);
        accept("t5_try1", 1'b0, 12'h333);
        accept("t5_try2", 1'b0, 12'h333);
        err_clr = 1'b1;
        repeat (16) tick();
        err_clr = 1'b0;
        chk("t5_err_wins", 32'(err_sticky), 32'd1);
        chk("t5_err_ch", 32'(err_ch), 32'd0);
        chk("t5_commit_kept", 32'(committed_value[11:0]), 32'hA01);
        chk("t5_idle", 32'(busy), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_err_clr", 32'(err_sticky), 32'd0);

        // 6: refresh resends committed values, then reset mid-ISSUE
        refresh_en = 1'b1;
        wait_valid(300, n);
        chk("t6_period", 32'(n), 32'd101);
        serve("t6_r1a", 1'b1, 12'h7E5, 1'b0);
        serve("t6_r1b", 1'b0, 12'hA01, 1'b0);
        serve("t6_r2a", 1'b1, 12'h7E5, 1'b0);
        serve("t6_r2b", 1'b0, 12'hA01, 1'b0);
        refresh_en = 1'b0;
        strobe(2'b01, 12'h444, 12'h000);
        wait_valid(10, n);
        chk("t6_issue", 32'(wr_value), 32'h444);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(wr_valid), 32'd0);
        chk("t6_rst_commit", 32'(committed_value), 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        rst = 1'b0;
        strobe(2'b11, 12'h0AA, 12'h0BB);
        serve("t6_post0", 1'b0, 12'h0AA, 1'b0);
        serve("t6_post1", 1'b1, 12'h0BB, 1'b0);
        chk("t6_post_commit", 32'(committed_value), 32'h0BB0AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
